pll_lock_reset_gen: RTL and testbench
=====================================

Name: pll_lock_reset_gen

Overview:
Sits directly downstream of the system PLL wrapper. Runs on the PLL's 22 MHz output and consumes its asynchronous lock indicator. Holds the core in reset until lock has been stable for a programmable settle time, re-asserts reset on any lock loss, and generates the pixel clock enable for the core.

Parameters:
SETTLE_CYCLES, 1024, consecutive synchronised-lock cycles required before releasing reset (>=1)
HOLD_CYCLES, 16, minimum reset-hold cycles after rst or lock loss, regardless of lock (>=1)
CE_DIV, 2, ce_pix period in clk cycles (>=1; 1 = enable every RUN cycle)

Ports:
clk  in  1  system clock, PLL 22 MHz output; sole clock
rst  in  1  reset, synchronous, active-high (user/HPS reset)
pll_locked  in  1  PLL lock, asynchronous to clk
core_reset  out  1  registered reset to core, active-high
ce_pix  out  1  registered one-cycle pixel clock enable
ready  out  1  registered; 1 only in RUN
lock_loss_cnt  out  8  saturating lock-loss count (see Optional Feature)

Behaviour:
- One clock (clk); rst is synchronous, active-high. All logic is on clk.
- pll_locked passes through a 2-FF synchroniser to give lk_s. Both FFs clear on rst.
- Single counter cnt, width $clog2(max(SETTLE_CYCLES,HOLD_CYCLES))+1. Divider div, width $clog2(CE_DIV)+1.
- On rst: state=HOLD, cnt=0, div=0, core_reset=1, ce_pix=0, ready=0, lock_loss_cnt=0. rst dominates every other event in any state.
- HOLD: if cnt==HOLD_CYCLES-1, go to WAIT_LOCK and set cnt=0; otherwise cnt++. lk_s is ignored.
- WAIT_LOCK: if lk_s=1, go to SETTLE and set cnt=0.
- SETTLE:
  - lk_s=0 -> WAIT_LOCK, cnt=0.
  - else if cnt==SETTLE_CYCLES-1 -> RUN, div=0.
  - else cnt++.
- RUN: lk_s=0 -> HOLD, cnt=0, and lock_loss_cnt increments, saturating at 255.
- Output timing:
  - core_reset=0 and ready=1 are written on the same edge that enters RUN.
  - core_reset=1 and ready=0 are written on the edge that leaves RUN.
- Latency: counting the first edge that samples pll_locked=1 as edge 1 (state WAIT_LOCK, sync already cleared), core_reset falls at edge SETTLE_CYCLES+3.
- Lock loss in RUN: core_reset rises on the 3rd edge after pll_locked falls.
- ce_pix, on each RUN edge:
  - if div==CE_DIV-1: div=0, ce_pix=1.
  - else: div++, ce_pix=0.
  - First pulse is written on the CE_DIV-th edge after core_reset falls.
  - ce_pix is forced to 0 on any edge whose next state is not RUN. It is never high while core_reset=1.
- Lock glitches shorter than the synchroniser are not filtered specially. Any lk_s=0 sample in SETTLE restarts settling.

Optional Feature:
LOCK_LOSS_CNT_EN
- Defined: lock_loss_cnt is an 8-bit register that increments on each RUN->HOLD transition caused by lk_s=0, saturates at 255, and is cleared only by rst.
- Undefined: no counter register; lock_loss_cnt is tied to 8'd0. All other behaviour is identical.

Test Plan:
- SETTLE_CYCLES=8, HOLD_CYCLES=4, CE_DIV=4, pll_locked=1 constant; rst high 4 cycles then low -> core_reset=1 through edge 12 after release, 0 written at edge 13, ready=1 at the same edge.
- Same params, lock rises while in WAIT_LOCK; in SETTLE at cnt=5, drop pll_locked for 3 cycles -> state returns to WAIT_LOCK, core_reset stays 1 throughout, full 8-cycle settle restarts after lk_s returns.
- In RUN with CE_DIV=4 -> ce_pix high exactly 1 cycle in 4, first at the 4th edge after core_reset falls. Repeat with CE_DIV=1 -> ce_pix=1 on every RUN edge.
- In RUN, drop pll_locked -> core_reset=1 and ce_pix=0 at the 3rd edge, then HOLD for 4 cycles. With LOCK_LOSS_CNT_EN, lock_loss_cnt goes 0->1. Restore lock -> reset released per the latency rule.
- LOCK_LOSS_CNT_EN: 260 lock-loss cycles -> lock_loss_cnt=255 (saturated). Pulse rst -> 0. Without the macro -> lock_loss_cnt=0 throughout.
- Assert rst mid-SETTLE (cnt=3) and mid-RUN -> on the next edge core_reset=1, ce_pix=0, ready=0, state HOLD, cnt=0.

Source files
------------

// File: rtl/pll_lock_reset_gen.sv
// pll_lock_reset_gen: holds the core in reset until the PLL lock indicator
// has been stable for SETTLE_CYCLES, re-asserts reset on lock loss, and
// generates the pixel clock enable while running.
// Optional macro LOCK_LOSS_CNT_EN adds a saturating lock-loss event counter;
// when undefined, lock_loss_cnt is tied to zero.
//
// FSM: HOLD -> WAIT_LOCK -> SETTLE -> RUN, with RUN -> HOLD on lock loss.
// The current state is visible as state_q, and the counters as cnt_q and div_q.
// All outputs are registered. core_reset, ready and ce_pix are derived from the
// next state, so they change on the same edge as the state transition.
module pll_lock_reset_gen #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CE_DIV        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       core_reset,
  output logic       ce_pix,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int DW      = $clog2(CE_DIV) + 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CE_DIV - 1);

  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_SETTLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic          sync1_q, sync1_d;
  logic          lk_s_q, lk_s_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          core_reset_q, core_reset_d;
  logic          ce_pix_q, ce_pix_d;
  logic          ready_q, ready_d;

  // Two-stage synchroniser inputs for the asynchronous lock indicator
  always_comb begin
    sync1_d = pll_locked;
    lk_s_d  = sync1_q;
  end

  // Sequencer next-state, counter, divider and registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    ce_pix_d = 1'b0;
    case (state_q)
      ST_HOLD: begin
        // Minimum hold time; lock state is deliberately ignored here.
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lk_s_q) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        // A lock drop wins over terminal count: any unlocked sample restarts.
        if (!lk_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (!lk_s_q) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d    = '0;
          ce_pix_d = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  // State and output registers; rst dominates every other event
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      lk_s_q       <= 1'b0;
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      div_q        <= '0;
      core_reset_q <= 1'b1;
      ce_pix_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      lk_s_q       <= lk_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      core_reset_q <= core_reset_d;
      ce_pix_q     <= ce_pix_d;
      ready_q      <= ready_d;
    end
  end

  assign core_reset = core_reset_q;
  assign ce_pix     = ce_pix_q;
  assign ready      = ready_q;

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] llc_q, llc_d;

  // Count RUN -> HOLD transitions caused by lock loss, saturating at 255
  always_comb begin
    llc_d = llc_q;
    if ((state_q == ST_RUN) && !lk_s_q && (llc_q != 8'hFF)) begin
      llc_d = llc_q + 8'd1;
    end
  end

  // Lock-loss counter register, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      llc_q <= 8'd0;
    end else begin
      llc_q <= llc_d;
    end
  end

  assign lock_loss_cnt = llc_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Directed bench for pll_lock_reset_gen. Two instances share the stimulus:
// dut0 uses CE_DIV=4 and dut1 uses CE_DIV=1. Both use SETTLE_CYCLES=8 and
// HOLD_CYCLES=4. Edge numbers in the comments count rising clock edges.
// Outputs are sampled 1 time unit after each edge.
module tb_pll_lock_reset_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       cr0, ce0, rdy0;
  logic       cr1, ce1, rdy1;
  logic [7:0] llc0, llc1;

  int checks = 0;
  int errors = 0;
  int losses = 0;

  // Expected {ce1, ce0} per RUN edge
  logic [1:0] exp_q[$];

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pll_lock_reset_gen #(.SETTLE_CYCLES(8), .HOLD_CYCLES(4), .CE_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .core_reset(cr0), .ce_pix(ce0), .ready(rdy0), .lock_loss_cnt(llc0)
  );

  pll_lock_reset_gen #(.SETTLE_CYCLES(8), .HOLD_CYCLES(4), .CE_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .core_reset(cr1), .ce_pix(ce1), .ready(rdy1), .lock_loss_cnt(llc1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] llc_exp(input int n);
    logic en;
    int   sat;
`ifdef LOCK_LOSS_CNT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    sat = (n > 255) ? 255 : n;
    return en ? 8'(sat) : 8'd0;
  endfunction

  // From RUN: drop lock for 3 edges, restore, and wait (bounded) for release.
  // The hold phase plus resync plus settle gives exactly 13 edges after HOLD entry.
  task automatic lose_and_recover();
    int n;
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    losses++;
    n = 0;
    while ((cr0 !== 1'b0) && (n < 40)) begin
      tick();
      n++;
    end
    chk("recover_edges", 8'(n), 8'd13);
    chk("llc_loop", llc0, llc_exp(losses));
  endtask

  initial begin
    logic [1:0] e;

    // Reset state
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("rst_core_reset0", cr0, 1);
    chk("rst_ce0", ce0, 0);
    chk("rst_ready0", rdy0, 0);
    chk("rst_llc0", llc0, 0);
    chk("rst_core_reset1", cr1, 1);
    chk("rst_ce1", ce1, 0);
    chk("rst_ready1", rdy1, 0);
    chk("rst_llc1", llc1, 0);

    // Release with lock constantly high: reset falls at edge 13
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("rel_core_reset", cr0, 1);
      chk("rel_ready", rdy0, 0);
    end
    tick();
    chk("run_core_reset0", cr0, 0);
    chk("run_ready0", rdy0, 1);
    chk("run_core_reset1", cr1, 0);
    chk("run_ready1", rdy1, 1);
    chk("run_entry_ce0", ce0, 0);
    chk("run_entry_ce1", ce1, 0);

    // Pixel enable: every 4th edge for CE_DIV=4, every edge for CE_DIV=1
    for (int k = 1; k <= 8; k++) exp_q.push_back({1'b1, (k % 4 == 0)});
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = exp_q.pop_front();
      chk("ce_div4", ce0, e[0]);
      chk("ce_div1", ce1, e[1]);
    end

    // Lock loss in RUN: reset rises on the 3rd edge
    pll_locked = 1'b0;
    tick();
    chk("loss_e1_core_reset", cr0, 0);
    tick();
    chk("loss_e2_core_reset", cr0, 0);
    chk("loss_e2_ce1", ce1, 1);
    tick();
    losses = 1;
    chk("loss_e3_core_reset0", cr0, 1);
    chk("loss_e3_core_reset1", cr1, 1);
    chk("loss_e3_ce0", ce0, 0);
    chk("loss_e3_ce1", ce1, 0);
    chk("loss_e3_ready", rdy0, 0);
    chk("loss_llc", llc0, llc_exp(1));
    // Restore at once: hold (4) + settle (8) + 1 → release at edge a16
    pll_locked = 1'b1;
    for (int a = 4; a <= 15; a++) begin
      tick();
      chk("relock_core_reset", cr0, 1);
    end
    tick();
    chk("relock_released", cr0, 0);
    chk("relock_ready", rdy0, 1);

    // Glitch in SETTLE at cnt=5 restarts the full settle
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    tick();
    chk("rst2_llc", llc0, 0);
    rst = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      tick();
      chk("glitch_wait_core_reset", cr0, 1);
    end
    pll_locked = 1'b1;
    for (int r = 7; r <= 14; r++) begin
      tick();
      chk("glitch_settle_core_reset", cr0, 1);
    end
    pll_locked = 1'b0;
    for (int r = 15; r <= 17; r++) begin
      tick();
      chk("glitch_low_core_reset", cr0, 1);
      chk("glitch_low_ready", rdy0, 0);
    end
    pll_locked = 1'b1;
    for (int r = 18; r <= 27; r++) begin
      tick();
      chk("glitch_resettle_core_reset", cr0, 1);
    end
    tick();
    chk("glitch_released", cr0, 0);
    chk("glitch_ready", rdy0, 1);

    // rst mid-RUN
    tick();
    chk("midrun_pre_ce1", ce1, 1);
    rst = 1'b1;
    tick();
    chk("midrun_core_reset0", cr0, 1);
    chk("midrun_core_reset1", cr1, 1);
    chk("midrun_ce1", ce1, 0);
    chk("midrun_ready", rdy0, 0);
    rst = 1'b0;

    // rst mid-SETTLE (cnt=3 after edge 8), then full release timing again
    for (int i = 1; i <= 8; i++) tick();
    rst = 1'b1;
    tick();
    chk("midsettle_core_reset", cr0, 1);
    chk("midsettle_ce", ce0, 0);
    chk("midsettle_ready", rdy0, 0);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("midsettle_rel_core_reset", cr0, 1);
    end
    tick();
    chk("midsettle_released", cr0, 0);

    // 260 lock losses: counter saturates (or stays zero without the feature)
    losses = 0;
    for (int i = 0; i < 260; i++) lose_and_recover();
    chk("llc_sat0", llc0, llc_exp(260));
    chk("llc_sat1", llc1, llc_exp(260));
    rst = 1'b1;
    tick();
    chk("llc_cleared", llc0, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
